// File: rtl/ccff_chain_loader.sv
// ----------------------------------------------------------------------------
// ccff_chain_loader
//   Loads an I/O-tile configuration flip-flop chain from a valid/ready word
//   stream. Each word is serialized LSB first onto ccff_head, with
//   ccff_shift_en qualifying each chain clock, until exactly CHAIN_LEN bits
//   have been shifted. isol_n holds the tiles isolated until the load is done.
//
//   Optional feature macro: CCFF_LOOPBACK_CHECK_EN
//     When defined, the chain is recirculated once after loading (tail fed
//     back to head). A CRC-8 of the loaded bits is compared with a CRC-8 of
//     the bits coming back out of ccff_tail. A mismatch raises cfg_err.
//     When undefined, cfg_err is tied low and no CRC logic exists.
//
// Ports
//   prog_clk       programming clock, all state on rising edge
//   prog_reset_n   asynchronous active-low reset
//   cfg_start      single-cycle load request (honoured in IDLE/DONE)
//   cfg_data       configuration word, DATA_W bits
//   cfg_valid      cfg_data valid
//   cfg_ready      word accepted this cycle when high with cfg_valid
//   ccff_tail      serial output of the last chain flip-flop
//   ccff_head      serial input to the first chain flip-flop
//   ccff_shift_en  chain clock enable
//   isol_n         tile isolation, 0 = isolated
//   cfg_busy       load or verify in progress
//   cfg_done       chain loaded (level, held until next accepted start)
//   cfg_err        loopback mismatch, valid while cfg_done is high
// ----------------------------------------------------------------------------
module ccff_chain_loader #(
    parameter int DATA_W    = 8,
    parameter int CHAIN_LEN = 4
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              cfg_start,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              ccff_tail,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              isol_n,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int BL_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] wreg_r;
    logic [WB_W-1:0]   wbits_r;
    logic [BL_W-1:0]   bits_left_r;
    logic              head_r;
    logic              shift_en_r;
    logic              isol_n_r;
    logic              busy_r;
    logic              done_r;

    logic              ready_s;
    logic              accept_s;
    logic [31:0]       rem_s;
    logic [WB_W-1:0]   load_bits_s;

`ifdef CCFF_LOOPBACK_CHECK_EN
    logic [7:0]        crc_load_r;
    logic [7:0]        crc_ver_r;
    logic [7:0]        crc_ver_next_s;
    logic [BL_W-1:0]   vcnt_r;
    logic              err_r;

    // Serial CRC-8, polynomial 0x07, one bit per call.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign crc_ver_next_s = crc8_step(crc_ver_r, ccff_tail);
    // During recirculation the head follows the tail so the chain is restored.
    assign ccff_head      = (state_r == ST_VERIFY) ? ccff_tail : head_r;
    assign cfg_err        = err_r;
`else
    logic unused_tail_s;
    assign unused_tail_s = ccff_tail;
    assign ccff_head     = head_r;
    assign cfg_err       = 1'b0;
`endif

    assign cfg_ready     = ready_s;
    assign ccff_shift_en = shift_en_r;
    assign isol_n        = isol_n_r;
    assign cfg_busy      = busy_r;
    assign cfg_done      = done_r;

    // Word acceptance: take a new word while the last bit of the previous one
    // is going out, but never fetch beyond the bits still owed to the chain.
    always_comb begin
        rem_s       = 32'(bits_left_r) - 32'(wbits_r);
        ready_s     = 1'b0;
        load_bits_s = {WB_W{1'b0}};
        if ((state_r == ST_SHIFT) && (32'(wbits_r) <= 32'd1) &&
            (32'(bits_left_r) > 32'(wbits_r))) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        if (rem_s > 32'(DATA_W)) begin
            load_bits_s = WB_W'(DATA_W);
        end else begin
            load_bits_s = WB_W'(rem_s);
        end
        accept_s = ready_s & cfg_valid;
    end

    // Loader state machine with registered chain-side outputs.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_r     <= ST_IDLE;
            wreg_r      <= {DATA_W{1'b0}};
            wbits_r     <= {WB_W{1'b0}};
            bits_left_r <= {BL_W{1'b0}};
            head_r      <= 1'b0;
            shift_en_r  <= 1'b0;
            isol_n_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef CCFF_LOOPBACK_CHECK_EN
            crc_load_r  <= 8'h00;
            crc_ver_r   <= 8'h00;
            vcnt_r      <= {BL_W{1'b0}};
            err_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (cfg_start) begin
                        state_r     <= ST_SHIFT;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        isol_n_r    <= 1'b0;
                        shift_en_r  <= 1'b0;
                        bits_left_r <= BL_W'(CHAIN_LEN);
                        wbits_r     <= {WB_W{1'b0}};
`ifdef CCFF_LOOPBACK_CHECK_EN
                        err_r       <= 1'b0;
                        crc_load_r  <= 8'h00;
                        crc_ver_r   <= 8'h00;
`endif
                    end else begin
                        shift_en_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (bits_left_r == {BL_W{1'b0}}) begin
                        // The last bit was captured by the chain at this edge.
`ifdef CCFF_LOOPBACK_CHECK_EN
                        state_r    <= ST_VERIFY;
                        shift_en_r <= 1'b1;
                        vcnt_r     <= BL_W'(CHAIN_LEN);
`else
                        state_r    <= ST_DONE;
                        shift_en_r <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        isol_n_r   <= 1'b1;
`endif
                    end else begin
                        if (wbits_r != {WB_W{1'b0}}) begin
                            head_r      <= wreg_r[0];
                            shift_en_r  <= 1'b1;
                            bits_left_r <= bits_left_r - BL_W'(1);
`ifdef CCFF_LOOPBACK_CHECK_EN
                            crc_load_r  <= crc8_step(crc_load_r, wreg_r[0]);
`endif
                        end else begin
                            // Stall: head keeps its value, chain not clocked.
                            shift_en_r <= 1'b0;
                        end
                        if (accept_s) begin
                            wreg_r  <= cfg_data;
                            wbits_r <= load_bits_s;
                        end else if (wbits_r != {WB_W{1'b0}}) begin
                            wreg_r  <= wreg_r >> 1;
                            wbits_r <= wbits_r - WB_W'(1);
                        end else begin
                            wreg_r <= wreg_r;
                        end
                    end
                end
`ifdef CCFF_LOOPBACK_CHECK_EN
                ST_VERIFY: begin
                    crc_ver_r <= crc_ver_next_s;
                    vcnt_r    <= vcnt_r - BL_W'(1);
                    if (vcnt_r == BL_W'(1)) begin
                        state_r    <= ST_DONE;
                        shift_en_r <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        isol_n_r   <= 1'b1;
                        err_r      <= (crc_load_r != crc_ver_next_s);
                    end else begin
                        shift_en_r <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_r    <= ST_IDLE;
                    shift_en_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    isol_n_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ----------------------------------------------------------------------------
// Bench for ccff_chain_loader. Two instances (CHAIN_LEN 4 and 12) share one
// clock; each drives a behavioural chain model. Expected chain bits are pushed
// to a scoreboard queue when a load is started and popped on every observed
// shift-enabled cycle. Honors CCFF_LOOPBACK_CHECK_EN when defined.
// ----------------------------------------------------------------------------
module tb_ccff_chain_loader;

`ifdef CCFF_LOOPBACK_CHECK_EN
    localparam int VMUL = 2;
`else
    localparam int VMUL = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       start [2];
    logic       valid [2];
    logic [7:0] data  [2];
    logic       ready [2];
    logic       head  [2];
    logic       sen   [2];
    logic       isol  [2];
    logic       busy  [2];
    logic       done  [2];
    logic       err   [2];
    logic [3:0]  chain4;
    logic [11:0] chain12;
    logic       flip;
    int         act;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nshift, nstall, first_shift_cyc;
    bit acc_last, skip_bits;
    bit q[$];

    ccff_chain_loader #(.DATA_W(8), .CHAIN_LEN(4)) u_dut4 (
        .prog_clk(clk), .prog_reset_n(rst_n), .cfg_start(start[0]),
        .cfg_data(data[0]), .cfg_valid(valid[0]), .cfg_ready(ready[0]),
        .ccff_tail(chain4[0]), .ccff_head(head[0]), .ccff_shift_en(sen[0]),
        .isol_n(isol[0]), .cfg_busy(busy[0]), .cfg_done(done[0]), .cfg_err(err[0]));

    ccff_chain_loader #(.DATA_W(8), .CHAIN_LEN(12)) u_dut12 (
        .prog_clk(clk), .prog_reset_n(rst_n), .cfg_start(start[1]),
        .cfg_data(data[1]), .cfg_valid(valid[1]), .cfg_ready(ready[1]),
        .ccff_tail(chain12[0]), .ccff_head(head[1]), .ccff_shift_en(sen[1]),
        .isol_n(isol[1]), .cfg_busy(busy[1]), .cfg_done(done[1]), .cfg_err(err[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain models: head enters at the top, chain[0] drives ccff_tail.
    always_ff @(posedge clk) begin
        if (sen[0]) chain4 <= {head[0], chain4[3:1]} ^ {3'b000, (flip && act == 0)};
        if (sen[1]) chain12 <= {head[1], chain12[11:1]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: inputs already set, observe after the falling edge.
    task automatic step();
        bit e;
        acc_last = valid[act] && ready[act];
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (sen[d]) begin
                if (d != act) begin
                    chk("idle_shift", 32'(sen[d]), 32'd0);
                end else begin
                    nshift++;
                    if (first_shift_cyc < 0) first_shift_cyc = cyc;
                    if (!skip_bits) begin
                        if (q.size() == 0) begin
                            chk("sb_underflow", 32'(q.size()), 32'd1);
                        end else begin
                            e = q.pop_front();
                            chk("bit", 32'(head[d]), 32'(e));
                        end
                    end
                end
            end else if (d == act && busy[d] && first_shift_cyc >= 0) begin
                nstall++;
            end
        end
    endtask

    task automatic chk_reset_outs(input int d);
        chk("rst_ready", 32'(ready[d]), 32'd0);
        chk("rst_head",  32'(head[d]),  32'd0);
        chk("rst_sen",   32'(sen[d]),   32'd0);
        chk("rst_isol",  32'(isol[d]),  32'd0);
        chk("rst_busy",  32'(busy[d]),  32'd0);
        chk("rst_done",  32'(done[d]),  32'd0);
        chk("rst_err",   32'(err[d]),   32'd0);
    endtask

    task automatic run_load(input int d, input logic [23:0] words, input int nw,
                            input int gap, input int mid_start_at, input int rst_at,
                            input int do_flip, input logic [11:0] exp_chain,
                            input int exp_acc, input int exp_stall, input logic exp_err);
        int n, idx, acc, gapc, acc_cyc, c_before;
        bit rdy_b;
        logic [11:0] got_chain;
        n = (d == 0) ? 4 : 12;
        act = d; q.delete(); nshift = 0; nstall = 0; first_shift_cyc = -1;
        skip_bits = (do_flip != 0);
        for (int r = 0; r < VMUL; r++)
            for (int i = 0; i < n; i++) q.push_back(words[i]);
        start[d] = 1'b1;
        step();
        start[d] = 1'b0;
        chk("start_busy", 32'(busy[d]), 32'd1);
        chk("start_done", 32'(done[d]), 32'd0);
        chk("start_isol", 32'(isol[d]), 32'd0);
        chk("start_err",  32'(err[d]),  32'd0);
        idx = 0; acc = 0; gapc = 0; acc_cyc = -1;
        valid[d] = 1'b1; data[d] = words[7:0];
        for (int t = 0; t < 200 && !done[d]; t++) begin
            rdy_b = ready[d]; c_before = cyc;
            start[d] = (mid_start_at > 0 && nshift == mid_start_at);
            flip = (do_flip != 0 && nshift == n);
            step();
            if (rst_at > 0 && nshift == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outs(d);
                @(negedge clk);
                rst_n = 1'b1; valid[d] = 1'b0; start[d] = 1'b0; flip = 1'b0;
                return;
            end
            if (acc_last) begin
                acc++; idx++;
                if (acc_cyc < 0) acc_cyc = c_before;
                if (idx >= nw) valid[d] = 1'b0;
                else data[d] = words[idx*8 +: 8];
                if (idx == 1 && gap > 0) begin
                    gapc = gap; valid[d] = 1'b0;
                end
            end else if (gapc > 0 && rdy_b) begin
                gapc--;
                if (gapc == 0 && idx < nw) valid[d] = 1'b1;
            end
        end
        start[d] = 1'b0; valid[d] = 1'b0; flip = 1'b0;
        got_chain = (d == 0) ? {8'h00, chain4} : chain12;
        chk("done",     32'(done[d]), 32'd1);
        chk("isol",     32'(isol[d]), 32'd1);
        chk("busy",     32'(busy[d]), 32'd0);
        chk("sen_off",  32'(sen[d]),  32'd0);
        chk("err",      32'(err[d]),  32'(exp_err));
        chk("shifts",   32'(nshift),  32'(n * VMUL));
        chk("stalls",   32'(nstall),  32'(exp_stall));
        chk("accepted", 32'(acc),     32'(exp_acc));
        chk("latency",  32'(first_shift_cyc - acc_cyc), 32'd2);
        if (do_flip == 0) begin
            chk("chain",   32'(got_chain), 32'(exp_chain));
            chk("sb_left", 32'(q.size()),  32'd0);
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0; act = 0; flip = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; valid[d] = 1'b0; data[d] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk_reset_outs(0);
        chk_reset_outs(1);
        rst_n = 1'b1;
        step();

        // word 0xA5 into a 4-bit chain: bits 1,0,1,0
        run_load(0, 24'h0000A5, 1, 0, 0, 0, 0, 12'h005, 1, 0, 1'b0);
        // two words back to back into a 12-bit chain; third word never taken
        run_load(1, 24'hFF053C, 3, 0, 0, 0, 0, 12'h53C, 2, 0, 1'b0);
        // valid dropped for 3 cycles after word 0 -> 3 stall cycles
        run_load(1, 24'h00053C, 2, 3, 0, 0, 0, 12'h53C, 2, 3, 1'b0);
        // start pulsed mid-shift is ignored
        run_load(1, 24'h0096C3, 2, 0, 3, 0, 0, 12'h6C3, 2, 0, 1'b0);
        // reset after two shifted bits, then a clean load of 0x0A
        run_load(0, 24'h00000F, 1, 0, 0, 2, 0, 12'h00F, 1, 0, 1'b0);
        run_load(0, 24'h00000A, 1, 0, 0, 0, 0, 12'h00A, 1, 0, 1'b0);
`ifdef CCFF_LOOPBACK_CHECK_EN
        run_load(0, 24'h00000F, 1, 0, 0, 0, 0, 12'h00F, 1, 0, 1'b0);
        run_load(0, 24'h00000F, 1, 0, 0, 0, 1, 12'h000, 1, 0, 1'b1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
